// File: rtl/led_driver_bank_if.sv
// ----------------------------------------------------------------------------
// led_driver_bank_if
//
// Single-cycle configuration write port for led_driver_bank. One write loads
// mode, blink rate and pending PWM duty of the channel selected by WSEL.
//
// Signals:
//   WE     write strobe, sampled on the rising CLK edge
//   WSEL   channel index (indices >= CHANNELS are ignored by the slave)
//   WMODE  mode code: 00 OFF, 01 ON, 10 BLINK, 11 PWM
//   WRATE  blink tap index into the prescaler
//   WDUTY  PWM duty value
//
// Modports:
//   master  drives the write port (host / testbench)
//   slave   receives the write port (led_driver_bank)
// ----------------------------------------------------------------------------
interface led_driver_bank_if #(
    parameter int CHANNELS = 5,
    parameter int PWM_BITS = 8
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                WE;
    logic [SEL_W-1:0]    WSEL;
    logic [1:0]          WMODE;
    logic [4:0]          WRATE;
    logic [PWM_BITS-1:0] WDUTY;

    modport master (
        output WE,
        output WSEL,
        output WMODE,
        output WRATE,
        output WDUTY
    );

    modport slave (
        input WE,
        input WSEL,
        input WMODE,
        input WRATE,
        input WDUTY
    );
endinterface

// File: rtl/led_driver_bank.sv
// ----------------------------------------------------------------------------
// led_driver_bank
//
// Multi-channel LED driver. A free-running prescaler counter feeds per-channel
// output logic; each channel runs OFF, ON, BLINK (a prescaler bit) or PWM
// (low prescaler bits compared against a duty). Duty changes are staged in a
// pending register and committed on PWM period boundaries so periods never
// glitch; mode and rate changes apply immediately.
//
// Parameters:
//   CHANNELS  number of LED outputs (1..16)
//   WIDTH     prescaler width (PWM_BITS+1..32)
//   PWM_BITS  PWM resolution (1..16)
//
// Ports:
//   CLK    sole clock, rising edge
//   RESET  synchronous active-high reset, priority over everything
//   wr     configuration write port (led_driver_bank_if.slave)
//   LED    registered LED drive, bit i = channel i
//   TICK   registered one-cycle pulse, high while cnt == 0 after a wrap
//
// Build option:
//   LED_DRIVER_BLINK_DEFAULT_EN  when defined, reset puts every channel into
//   BLINK at the slowest tap (WIDTH-1) for a power-on heartbeat; otherwise
//   reset leaves every channel OFF.
// ----------------------------------------------------------------------------
module led_driver_bank #(
    parameter int CHANNELS = 5,
    parameter int WIDTH    = 24,
    parameter int PWM_BITS = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    led_driver_bank_if.slave    wr,
    output logic [CHANNELS-1:0] LED,
    output logic                TICK
);

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PWM   = 2'b11;

    // Highest usable blink tap; WIDTH <= 32 so it always fits in 5 bits.
    localparam logic [4:0] TAP_MAX = 5'(WIDTH - 1);

`ifdef LED_DRIVER_BLINK_DEFAULT_EN
    localparam logic [1:0] RST_MODE = MODE_BLINK;
    localparam logic [4:0] RST_RATE = TAP_MAX;
`else
    localparam logic [1:0] RST_MODE = MODE_OFF;
    localparam logic [4:0] RST_RATE = 5'd0;
`endif

    // Clamp a requested blink tap to the prescaler's top bit.
    function automatic logic [4:0] sat_tap(input logic [4:0] req);
        return (req > TAP_MAX) ? TAP_MAX : req;
    endfunction

    logic [WIDTH-1:0]    cnt;
    logic [CHANNELS-1:0] led_next_p0;
    logic                commit_p0;
    logic                wrap_p0;
    logic                wr_hit_p0;

    // ---- stage p0: decode of prescaler state and write port -------------
    always_comb begin
        commit_p0 = &cnt[PWM_BITS-1:0];
        wrap_p0   = &cnt;
        // Out-of-range channel indices are dropped here so no channel sees them.
        wr_hit_p0 = wr.WE && (int'(wr.WSEL) < CHANNELS);
    end

    // ---- per-channel configuration and next-LED logic --------------------
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [1:0]          mode;
        logic [4:0]          rate;
        logic [PWM_BITS-1:0] duty_pend;
        logic [PWM_BITS-1:0] duty_act;
        logic                sel_hit;
        logic [4:0]          tap;
        logic                led_ch;

        assign sel_hit = wr_hit_p0 && (wr.WSEL == SEL_W'(g));
        assign tap     = sat_tap(rate);

        always_comb begin
            led_ch = 1'b0;
            case (mode)
                MODE_OFF:   led_ch = 1'b0;
                MODE_ON:    led_ch = 1'b1;
                // Mask-and-reduce picks cnt[tap] without a variable part-select.
                MODE_BLINK: led_ch = |(cnt & (WIDTH'(1) << tap));
                MODE_PWM:   led_ch = (cnt[PWM_BITS-1:0] < duty_act);
                default:    led_ch = 1'b0;
            endcase
        end

        assign led_next_p0[g] = led_ch;

        // Commit reads duty_pend before this edge's write lands, so a write
        // on a boundary edge waits for the following boundary.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                mode      <= RST_MODE;
                rate      <= RST_RATE;
                duty_pend <= '0;
                duty_act  <= '0;
            end else begin
                if (commit_p0) begin
                    duty_act <= duty_pend;
                end
                if (sel_hit) begin
                    mode      <= wr.WMODE;
                    rate      <= wr.WRATE;
                    duty_pend <= wr.WDUTY;
                end
            end
        end
    end

    // ---- stage p1: registered prescaler and outputs ----------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt  <= '0;
            LED  <= '0;
            TICK <= 1'b0;
        end else begin
            cnt  <= cnt + WIDTH'(1);
            LED  <= led_next_p0;
            TICK <= wrap_p0;
        end
    end

endmodule
